// File: rtl/iq_decim_avg.sv
// I/Q accumulate-and-dump decimator: averages DECIM ADC samples per output over valid/ready.
// Optional rounding (round half up) is enabled by defining IQ_DECIM_ROUND_EN; default truncates.
//
// phase | meaning
// ------+-----------------------------------------------------------
// ACC   | cnt < DECIM-1, strobed samples add into acc_i/acc_q
// DUMP  | cnt = DECIM-1, strobed sample completes the frame and loads output
module iq_decim_avg #(
    parameter int DATA_W = 8,
    parameter int DECIM  = 4
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     sample_valid,
    input  logic signed [DATA_W-1:0] i_in,
    input  logic signed [DATA_W-1:0] q_in,
    input  logic                     clear,
    output logic signed [DATA_W-1:0] i_out,
    output logic signed [DATA_W-1:0] q_out,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     overrun
);

    localparam int L  = $clog2(DECIM);
    localparam int AW = DATA_W + L;

    localparam logic [L-1:0] CNT_LAST = L'(DECIM - 1);

`ifdef IQ_DECIM_ROUND_EN
    localparam logic signed [AW-1:0] BIAS = AW'(DECIM / 2);
`else
    localparam logic signed [AW-1:0] BIAS = '0;
`endif

    logic [L-1:0]         cnt;
    logic signed [AW-1:0] acc_i;
    logic signed [AW-1:0] acc_q;

    logic signed [AW-1:0] ext_i;
    logic signed [AW-1:0] ext_q;
    logic signed [AW-1:0] sum_i;
    logic signed [AW-1:0] sum_q;
    logic signed [AW-1:0] rnd_i;
    logic signed [AW-1:0] rnd_q;
    logic                 dump;
    logic                 unused_lsb;

    assign ext_i = {{L{i_in[DATA_W-1]}}, i_in};
    assign ext_q = {{L{q_in[DATA_W-1]}}, q_in};
    assign sum_i = acc_i + ext_i;
    assign sum_q = acc_q + ext_q;
    // A full frame of DECIM samples plus the bias always fits in AW bits.
    assign rnd_i = sum_i + BIAS;
    assign rnd_q = sum_q + BIAS;
    assign dump  = sample_valid && (cnt == CNT_LAST);

    // Fractional bits are dropped by the divide-by-DECIM shift.
    assign unused_lsb = ^{rnd_i[L-1:0], rnd_q[L-1:0]};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt       <= '0;
            acc_i     <= '0;
            acc_q     <= '0;
            i_out     <= '0;
            q_out     <= '0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
        end else if (clear) begin
            cnt       <= '0;
            acc_i     <= '0;
            acc_q     <= '0;
            i_out     <= '0;
            q_out     <= '0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (dump) begin
                i_out     <= rnd_i[AW-1:L];
                q_out     <= rnd_q[AW-1:L];
                acc_i     <= '0;
                acc_q     <= '0;
                cnt       <= '0;
                out_valid <= 1'b1;
                if (out_valid && !out_ready) begin
                    overrun <= 1'b1;
                end
            end else begin
                if (sample_valid) begin
                    acc_i <= sum_i;
                    acc_q <= sum_q;
                    cnt   <= cnt + L'(1);
                end
                if (out_valid && out_ready) begin
                    out_valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_iq_decim_avg.sv
// Self-checking bench for iq_decim_avg: directed scenarios plus randomized traffic
// against a frame-level average model (floor division of the frame sum).
module tb_iq_decim_avg;

    localparam int DATA_W = 8;
    localparam int DECIM  = 4;
`ifdef IQ_DECIM_ROUND_EN
    localparam bit ROUND = 1'b1;
`else
    localparam bit ROUND = 1'b0;
`endif

    logic                     clk;
    logic                     resetn;
    logic                     sample_valid;
    logic signed [DATA_W-1:0] i_in;
    logic signed [DATA_W-1:0] q_in;
    logic                     clear;
    logic signed [DATA_W-1:0] i_out;
    logic signed [DATA_W-1:0] q_out;
    logic                     out_valid;
    logic                     out_ready;
    logic                     overrun;

    int checks = 0;
    int errors = 0;

    int frame_i[$];
    int frame_q[$];
    logic signed [DATA_W-1:0] exp_i;
    logic signed [DATA_W-1:0] exp_q;
    logic                     exp_valid;
    logic                     exp_ovr;

    iq_decim_avg #(.DATA_W(DATA_W), .DECIM(DECIM)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .sample_valid (sample_valid),
        .i_in         (i_in),
        .q_in         (q_in),
        .clear        (clear),
        .i_out        (i_out),
        .q_out        (q_out),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .overrun      (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Average of a whole frame: floor((sum + bias) / DECIM).
    function automatic int avg_ref(input int s);
        int t;
        int qv;
        t  = s + (ROUND ? DECIM / 2 : 0);
        qv = t / DECIM;
        if ((t % DECIM != 0) && (t < 0)) qv = qv - 1;
        return qv;
    endfunction

    task automatic model_reset();
        frame_i.delete();
        frame_q.delete();
        exp_i     = '0;
        exp_q     = '0;
        exp_valid = 1'b0;
        exp_ovr   = 1'b0;
    endtask

    // Drive one cycle of inputs, clock it, then advance the model to the post-edge state.
    task automatic step(input bit sv, input int iv, input int qv, input bit rdy, input bit clr);
        bit accepted;
        bit loaded;
        int si;
        int sq;
        sample_valid = sv;
        i_in         = DATA_W'(iv);
        q_in         = DATA_W'(qv);
        out_ready    = rdy;
        clear        = clr;
        @(posedge clk);
        #1;
        if (clr) begin
            model_reset();
        end else begin
            accepted = exp_valid && rdy;
            loaded   = 1'b0;
            if (sv) begin
                frame_i.push_back(iv);
                frame_q.push_back(qv);
                if (frame_i.size() == DECIM) begin
                    si = 0;
                    sq = 0;
                    foreach (frame_i[k]) si += frame_i[k];
                    foreach (frame_q[k]) sq += frame_q[k];
                    if (exp_valid && !rdy) exp_ovr = 1'b1;
                    exp_i     = DATA_W'(avg_ref(si));
                    exp_q     = DATA_W'(avg_ref(sq));
                    exp_valid = 1'b1;
                    loaded    = 1'b1;
                    frame_i.delete();
                    frame_q.delete();
                end
            end
            if (!loaded && accepted) exp_valid = 1'b0;
        end
        sample_valid = 1'b0;
        clear        = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b1; sample_valid = 1'b0; i_in = '0; q_in = '0; clear = 1'b0; out_ready = 1'b0;
        #2 resetn = 1'b0;
        #10;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0d want 0", out_valid); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got %0d want 0", overrun); end
        checks++; if (i_out !== 8'sd0) begin errors++; $display("FAIL reset_i got %0d want 0", i_out); end
        checks++; if (q_out !== 8'sd0) begin errors++; $display("FAIL reset_q got %0d want 0", q_out); end
        model_reset();
        #10 resetn = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_directed();
        int iv[4] = '{10, 20, 30, 42};
        int qv[4] = '{-1, -1, -1, -2};
        for (int k = 0; k < 4; k++) begin
            step(1'b1, iv[k], qv[k], 1'b1, 1'b0);
            if (k < 3) begin
                checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL dir_early_valid k=%0d got %0d want 0", k, out_valid); end
            end
        end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL dir_valid got %0d want 1", out_valid); end
        checks++; if (i_out !== DATA_W'(ROUND ? 26 : 25)) begin errors++; $display("FAIL dir_i got %0d want %0d", i_out, ROUND ? 26 : 25); end
        checks++; if (q_out !== DATA_W'(ROUND ? -1 : -2)) begin errors++; $display("FAIL dir_q got %0d want %0d", q_out, ROUND ? -1 : -2); end
        step(1'b0, 0, 0, 1'b1, 1'b0);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL dir_one_cycle got %0d want 0", out_valid); end
        for (int k = 0; k < 4; k++) step(1'b1, 127, -128, 1'b1, 1'b0);
        checks++; if (i_out !== 8'sd127) begin errors++; $display("FAIL max_i got %0d want 127", i_out); end
        checks++; if (q_out !== -8'sd128) begin errors++; $display("FAIL min_q got %0d want -128", q_out); end
        step(1'b0, 0, 0, 1'b1, 1'b0);
    endtask

    task automatic test_overrun();
        logic signed [DATA_W-1:0] first_i;
        for (int k = 0; k < 4; k++) step(1'b1, 4 * k + 1, -3 * k, 1'b0, 1'b0);
        first_i = exp_i;
        checks++; if (out_valid !== 1'b1 || i_out !== first_i) begin errors++; $display("FAIL ovr_first got v=%0d i=%0d want v=1 i=%0d", out_valid, i_out, first_i); end
        for (int k = 0; k < 3; k++) begin
            step(1'b1, -50 + k, 60 - k, 1'b0, 1'b0);
            checks++; if (out_valid !== 1'b1 || i_out !== first_i || overrun !== 1'b0) begin errors++; $display("FAIL ovr_hold got v=%0d i=%0d o=%0d want v=1 i=%0d o=0", out_valid, i_out, overrun, first_i); end
        end
        step(1'b1, -60, 70, 1'b0, 1'b0);
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_set got %0d want 1", overrun); end
        checks++; if (i_out !== exp_i || q_out !== exp_q) begin errors++; $display("FAIL ovr_new got i=%0d q=%0d want i=%0d q=%0d", i_out, q_out, exp_i, exp_q); end
        step(1'b0, 0, 0, 1'b1, 1'b0);
        checks++; if (out_valid !== 1'b0 || overrun !== 1'b1) begin errors++; $display("FAIL ovr_sticky got v=%0d o=%0d want v=0 o=1", out_valid, overrun); end
        step(1'b0, 0, 0, 1'b0, 1'b1);
        checks++; if (out_valid !== 1'b0 || overrun !== 1'b0) begin errors++; $display("FAIL ovr_clear got v=%0d o=%0d want 0 0", out_valid, overrun); end
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 4; k++) step(1'b1, 100 - k, k, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) step(1'b1, -7 * k, 3 + k, (k == 3), 1'b0);
        checks++; if (out_valid !== 1'b1 || overrun !== 1'b0) begin errors++; $display("FAIL b2b_flags got v=%0d o=%0d want 1 0", out_valid, overrun); end
        checks++; if (i_out !== exp_i || q_out !== exp_q) begin errors++; $display("FAIL b2b_value got i=%0d q=%0d want i=%0d q=%0d", i_out, q_out, exp_i, exp_q); end
        step(1'b0, 0, 0, 1'b1, 1'b0);
    endtask

    task automatic test_clear_mid();
        step(1'b1, 90, 90, 1'b1, 1'b0);
        step(1'b1, 90, 90, 1'b1, 1'b0);
        step(1'b1, 90, 90, 1'b1, 1'b1);
        for (int k = 0; k < 4; k++) step(1'b1, -20 + 4 * k, 8 * k, 1'b1, 1'b0);
        checks++; if (out_valid !== 1'b1 || i_out !== exp_i || q_out !== exp_q) begin errors++; $display("FAIL clear_mid got v=%0d i=%0d q=%0d want v=1 i=%0d q=%0d", out_valid, i_out, q_out, exp_i, exp_q); end
        step(1'b0, 0, 0, 1'b1, 1'b0);
    endtask

    task automatic test_reset_mid();
        for (int k = 0; k < 4; k++) step(1'b1, 33, 44, 1'b0, 1'b0);
        step(1'b1, 5, 5, 1'b0, 1'b0);
        #2 resetn = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || i_out !== 8'sd0 || q_out !== 8'sd0 || overrun !== 1'b0) begin errors++; $display("FAIL async_reset got v=%0d i=%0d q=%0d o=%0d want all 0", out_valid, i_out, q_out, overrun); end
        model_reset();
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) step(1'b1, 11 * k - 9, -13 * k, 1'b1, 1'b0);
        checks++; if (out_valid !== 1'b1 || i_out !== exp_i || q_out !== exp_q) begin errors++; $display("FAIL post_reset got v=%0d i=%0d q=%0d want v=1 i=%0d q=%0d", out_valid, i_out, q_out, exp_i, exp_q); end
        step(1'b0, 0, 0, 1'b1, 1'b0);
    endtask

    task automatic test_random();
        bit sv, rdy, clr;
        int iv, qv;
        for (int n = 0; n < 800; n++) begin
            sv  = ($urandom_range(0, 3) != 0);
            rdy = ($urandom_range(0, 2) == 0);
            clr = ($urandom_range(0, 79) == 0);
            iv  = int'($urandom_range(0, 255)) - 128;
            qv  = int'($urandom_range(0, 255)) - 128;
            step(sv, iv, qv, rdy, clr);
            checks++; if (out_valid !== exp_valid || overrun !== exp_ovr) begin errors++; $display("FAIL rnd_flags n=%0d got v=%0d o=%0d want v=%0d o=%0d", n, out_valid, overrun, exp_valid, exp_ovr); end
            checks++; if (i_out !== exp_i || q_out !== exp_q) begin errors++; $display("FAIL rnd_data n=%0d got i=%0d q=%0d want i=%0d q=%0d", n, i_out, q_out, exp_i, exp_q); end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_overrun();
        test_back_to_back();
        test_clear_mid();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/iq_decim_avg.md
# iq_decim_avg

I/Q accumulate-and-dump decimator directly downstream of the ADC-ready edge detector in the IQ demodulator. It consumes the single-cycle sample strobe and the signed I/Q ADC words. It averages every DECIM consecutive samples into one output sample, delivered over a valid/ready handshake to the demodulator core. Overruns from a stalled consumer are flagged sticky rather than back-pressuring the ADC path.

## Interface
- DATA_W, 8, signed width of I/Q input and output samples (4..16)
- DECIM, 4, decimation ratio; power of two, 2..16; L = $clog2(DECIM)
- clk  in  1  system clock; all logic on rising edge
- resetn  in  1  reset, asynchronous, active-low
- sample_valid  in  1  one-cycle strobe per new ADC sample (from edge detector)
- i_in  in  DATA_W  signed I sample, valid when sample_valid=1
- q_in  in  DATA_W  signed Q sample, valid when sample_valid=1
- clear  in  1  synchronous restart: flush accumulators, counter, output, overrun
- i_out  out  DATA_W  signed averaged I
- q_out  out  DATA_W  signed averaged Q
- out_valid  out  1  i_out/q_out hold a result not yet accepted
- out_ready  in  1  consumer accepts when out_valid & out_ready at clock edge
- overrun  out  1  sticky: an unaccepted result was overwritten

## Operation
- State: phase counter cnt (0..DECIM-1) plus accumulators acc_i, acc_q, each signed DATA_W+L bits (never overflow).
- Phases: ACC (cnt < DECIM-1) and DUMP (cnt = DECIM-1); output register is a separate FULL/EMPTY flag (out_valid).
- sample_valid in ACC: acc += in (sign-extended), cnt++.
- sample_valid in DUMP: sum = acc + in; result = sum >>> L (arithmetic); load i_out/q_out; out_valid <= 1; acc <= 0; cnt <= 0.
- Handshake: out_valid falls at the edge where out_valid & out_ready, unless a new result loads on that same edge (then out_valid stays 1 and no overrun).
- Load while out_valid=1 and out_ready=0: new result overwrites; overrun <= 1 (sticky).
- out_valid, i_out, q_out stable while out_valid=1 and not accepted and no new load.
- clear: acc, cnt, out_valid, overrun <= 0; i_out/q_out <= 0; clear dominates sample_valid and out_ready in the same cycle.
- sample_valid ignored only when clear=1; no other gating; strobes need not be periodic.

## Timing
- Reset (resetn low, async): cnt=0, acc_i=acc_q=0, i_out=q_out=0, out_valid=0, overrun=0.
- Latency: out_valid rises on the edge that samples the DECIM-th sample_valid; visible the following cycle.
- Throughput: one input per clock sustained; one output per DECIM inputs.
- Reset released mid-frame: accumulation restarts at cnt=0; partial frames before reset are discarded.
- Back-to-back sample_valid on consecutive cycles across a DUMP boundary: next frame's first sample accumulates into zeroed acc in the following cycle; no sample lost.

## Configuration
- IQ_DECIM_ROUND_EN defined: result = (sum + 2^(L-1)) >>> L (round half up); no saturation needed since |sum + 2^(L-1)| stays within range.
- IQ_DECIM_ROUND_EN undefined: result = sum >>> L (truncate toward minus infinity).

## Test plan
- Reset then DECIM=4, I = 10,20,30,42 with out_ready=1 -> out_valid one cycle, i_out = 25 (truncate) / 26 (ROUND_EN).
- Q = -1,-1,-1,-2 -> q_out = -2 (truncate) / -1 (ROUND_EN); I all 127 -> i_out=127; all -128 -> -128.
- out_ready=0 over two full frames -> first result held, then overwritten by second, overrun=1 and stays 1 after accept; clear -> overrun=0, out_valid=0.
- Accept coincident with new load (out_ready=1 on DUMP edge while out_valid=1) -> out_valid stays 1, new value shown, overrun stays 0.
- clear asserted with sample_valid after 2 of 4 samples -> cnt=0; next 4 samples produce average of those 4 only.
- resetn pulsed low mid-frame with out_valid=1 -> all outputs 0 immediately (asynchronous); next full frame averages correctly.
